example_text_memory_loader: RTL



---
 rtl/example_text_memory_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/example_text_memory_loader.sv
// Boot loader: packs a valid/ready byte stream (LE word-count header, LE payload) into text memory words.
// Write strobe 1 cycle after each lane-3 byte; no memory backpressure. Optional checksum trailer: LOADER_CHECKSUM_EN.
module example_text_memory_loader #(
  parameter int          TEXT_BITS  = 16,
  parameter logic [31:0] TEXT_BEGIN = 32'h00400000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [TEXT_BITS-3:0] mem_address,
  output logic [31:0]          mem_write_data,
  output logic                 mem_write_enable,
  output logic [31:0]          load_address,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int          AW       = TEXT_BITS - 2;
  localparam int          CW       = TEXT_BITS - 1;
  localparam logic [32:0] CAPACITY = 33'd1 << AW;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_CHECK, S_DONE, S_ERROR} state_t;
  localparam state_t S_FINISH = S_CHECK;
  logic [31:0] sum_q;
`else
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_DONE, S_ERROR} state_t;
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t          state, state_nxt;
  logic [1:0]      byte_cnt;
  logic [CW-1:0]   word_cnt;
  logic [23:0]     asm_q;
  logic [31:0]     word_total;
  logic            accept, lane_done, last_word;
  logic [31:0]     full_word;

  assign accept    = in_valid && in_ready;
  assign lane_done = accept && (byte_cnt == 2'd3);
  assign full_word = {in_data, asm_q};
  // word_cnt is the index of the word being assembled or strobed
  assign last_word = (32'(word_cnt) + 32'd1) == word_total;

  // the final word's strobe must not overlap a stray payload byte
  assign in_ready = (state == S_HEADER)
`ifdef LOADER_CHECKSUM_EN
                 || (state == S_CHECK)
`endif
                 || ((state == S_DATA) && !(mem_write_enable && last_word));

  assign busy  = (state == S_HEADER) || (state == S_DATA)
`ifdef LOADER_CHECKSUM_EN
              || (state == S_CHECK)
`endif
              ;
  assign done  = (state == S_DONE);
  assign error = (state == S_ERROR);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_HEADER;
      S_HEADER: if (lane_done) begin
        if (full_word == 32'd0)                 state_nxt = S_FINISH;
        else if ({1'b0, full_word} > CAPACITY)  state_nxt = S_ERROR;
        else                                    state_nxt = S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_DATA:  if (lane_done && last_word) state_nxt = S_CHECK;
      S_CHECK: if (lane_done) state_nxt = (full_word == sum_q) ? S_DONE : S_ERROR;
`else
      S_DATA:  if (mem_write_enable && last_word) state_nxt = S_DONE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      byte_cnt         <= '0;
      word_cnt         <= '0;
      asm_q            <= '0;
      word_total       <= '0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= '0;
      mem_address      <= '0;
      load_address     <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q            <= '0;
`endif
    end else begin
      mem_write_enable <= 1'b0;
      if (mem_write_enable) word_cnt <= word_cnt + 1'b1;
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt != 2'd3) asm_q[{byte_cnt, 3'b000} +: 8] <= in_data;
      end
      if (state == S_HEADER && lane_done) word_total <= full_word;
      if (state == S_DATA && lane_done) begin
        mem_write_enable <= 1'b1;
        mem_write_data   <= full_word;
        mem_address      <= word_cnt[AW-1:0];
        load_address     <= TEXT_BEGIN + 32'({word_cnt[AW-1:0], 2'b00});
`ifdef LOADER_CHECKSUM_EN
        sum_q            <= sum_q + full_word;
`endif
      end
      if (start && !busy) begin
        byte_cnt <= '0;
        word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum_q    <= '0;
`endif
      end
    end
  end

endmodule
